// File: rtl/cv32e40p_pc_redirect_ctrl_if.sv
// Redirect request/select bundle between the requesters, the prefetcher and the
// fetch-address redirect sequencer.
interface cv32e40p_pc_redirect_ctrl_if;
    logic        fetch_enable_i;
    logic [10:0] req_i;
    logic [4:0]  irq_id_i;
    logic        trap_user_i;
    logic        fence_done_i;
    logic        fetch_ready_i;
    logic        pc_set_o;
    logic [3:0]  pc_mux_o;
    logic [2:0]  exc_pc_mux_o;
    logic [1:0]  trap_addr_mux_o;
    logic [4:0]  irq_id_o;
    logic [10:0] grant_o;
    logic        csr_mtvec_init_o;
    logic        busy_o;

    modport slave (
        input  fetch_enable_i, req_i, irq_id_i, trap_user_i, fence_done_i, fetch_ready_i,
        output pc_set_o, pc_mux_o, exc_pc_mux_o, trap_addr_mux_o, irq_id_o, grant_o,
        csr_mtvec_init_o, busy_o
    );

    modport master (
        output fetch_enable_i, req_i, irq_id_i, trap_user_i, fence_done_i, fetch_ready_i,
        input  pc_set_o, pc_mux_o, exc_pc_mux_o, trap_addr_mux_o, irq_id_o, grant_o,
        csr_mtvec_init_o, busy_o
    );
endinterface

// File: rtl/cv32e40p_pc_redirect_ctrl.sv
// Fixed-priority redirect sequencer driving the fetch-address mux selects and pc_set
// under a valid/ready handshake; handles boot and fence.i drain.
module cv32e40p_pc_redirect_ctrl (
    input logic                       clk,
    input logic                       rst,
    cv32e40p_pc_redirect_ctrl_if.slave bus
);
    localparam logic [3:0] PC_BOOT      = 4'b0000;
    localparam logic [3:0] PC_FENCEI    = 4'b0001;
    localparam logic [3:0] PC_JUMP      = 4'b0010;
    localparam logic [3:0] PC_BRANCH    = 4'b0011;
    localparam logic [3:0] PC_EXCEPTION = 4'b0100;
    localparam logic [3:0] PC_MRET      = 4'b0101;
    localparam logic [3:0] PC_URET      = 4'b0110;
    localparam logic [3:0] PC_DRET      = 4'b0111;
    localparam logic [3:0] PC_HWLOOP    = 4'b1000;

    localparam logic [2:0] EXC_PC_EXCEPTION = 3'b000;
    localparam logic [2:0] EXC_PC_IRQ       = 3'b001;
    localparam logic [2:0] EXC_PC_DBD       = 3'b010;
    localparam logic [2:0] EXC_PC_DBE       = 3'b011;

    localparam logic [1:0] TRAP_MACHINE = 2'b00;
    localparam logic [1:0] TRAP_USER    = 2'b01;

    // Selection indices match req_i bit positions; BOOT sits outside the request vector.
    localparam logic [3:0] SEL_HWLP     = 4'd0;
    localparam logic [3:0] SEL_JUMP     = 4'd1;
    localparam logic [3:0] SEL_FENCEI   = 4'd2;
    localparam logic [3:0] SEL_BRANCH   = 4'd3;
    localparam logic [3:0] SEL_URET     = 4'd4;
    localparam logic [3:0] SEL_MRET     = 4'd5;
    localparam logic [3:0] SEL_DRET     = 4'd6;
    localparam logic [3:0] SEL_IRQ      = 4'd7;
    localparam logic [3:0] SEL_EXC      = 4'd8;
    localparam logic [3:0] SEL_DBG_EXC  = 4'd9;
    localparam logic [3:0] SEL_DBG_HALT = 4'd10;
    localparam logic [3:0] SEL_BOOT     = 4'd11;

    typedef enum logic [1:0] {BOOT_WAIT, RUN, FENCE_WAIT, ISSUE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  sel;
    logic [3:0]  cand;
    logic        load;
    logic [3:0]  pc_mux_q, pc_mux_nxt;
    logic [2:0]  exc_pc_mux_q, exc_pc_mux_nxt;
    logic [1:0]  trap_addr_mux_q, trap_addr_mux_nxt;
    logic [4:0]  irq_id_q, irq_id_nxt;
    logic        accept;

    // Highest set bit wins; later loop iterations overwrite lower-priority hits.
    function automatic logic [3:0] pick(input logic [10:0] req);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (req[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        cand      = sel;
        case (state)
            BOOT_WAIT: begin
                if (bus.fetch_enable_i) begin
                    load      = 1'b1;
                    cand      = SEL_BOOT;
                    state_nxt = ISSUE;
                end
            end
            RUN: begin
                if (|bus.req_i) begin
                    load      = 1'b1;
                    cand      = pick(bus.req_i);
                    state_nxt = (cand == SEL_FENCEI) ? FENCE_WAIT : ISSUE;
                end
            end
            FENCE_WAIT: begin
                // Debug and exceptions abandon the pending fence; it is re-requested later.
                if (|bus.req_i[10:8]) begin
                    load      = 1'b1;
                    cand      = pick({bus.req_i[10:8], 8'b0});
                    state_nxt = ISSUE;
                end else if (bus.fence_done_i) begin
                    load      = 1'b1;
                    cand      = SEL_FENCEI;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) state_nxt = RUN;
            end
            default: state_nxt = BOOT_WAIT;
        endcase
    end

    always_comb begin
        pc_mux_nxt        = PC_BOOT;
        exc_pc_mux_nxt    = EXC_PC_EXCEPTION;
        trap_addr_mux_nxt = TRAP_MACHINE;
        irq_id_nxt        = 5'd0;
        case (cand)
            SEL_DBG_HALT: begin
                pc_mux_nxt     = PC_EXCEPTION;
                exc_pc_mux_nxt = EXC_PC_DBD;
            end
            SEL_DBG_EXC: begin
                pc_mux_nxt     = PC_EXCEPTION;
                exc_pc_mux_nxt = EXC_PC_DBE;
            end
            SEL_EXC: begin
                pc_mux_nxt        = PC_EXCEPTION;
                exc_pc_mux_nxt    = EXC_PC_EXCEPTION;
                trap_addr_mux_nxt = bus.trap_user_i ? TRAP_USER : TRAP_MACHINE;
            end
            SEL_IRQ: begin
                pc_mux_nxt        = PC_EXCEPTION;
                exc_pc_mux_nxt    = EXC_PC_IRQ;
                trap_addr_mux_nxt = bus.trap_user_i ? TRAP_USER : TRAP_MACHINE;
                irq_id_nxt        = bus.irq_id_i;
            end
            SEL_DRET:   pc_mux_nxt = PC_DRET;
            SEL_MRET:   pc_mux_nxt = PC_MRET;
            SEL_URET:   pc_mux_nxt = PC_URET;
            SEL_BRANCH: pc_mux_nxt = PC_BRANCH;
            SEL_FENCEI: pc_mux_nxt = PC_FENCEI;
            SEL_JUMP:   pc_mux_nxt = PC_JUMP;
            SEL_HWLP:   pc_mux_nxt = PC_HWLOOP;
            default:    pc_mux_nxt = PC_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= BOOT_WAIT;
            sel             <= SEL_BOOT;
            pc_mux_q        <= PC_BOOT;
            exc_pc_mux_q    <= EXC_PC_EXCEPTION;
            trap_addr_mux_q <= TRAP_MACHINE;
            irq_id_q        <= 5'd0;
        end else begin
            state <= state_nxt;
            if (load) begin
                sel             <= cand;
                pc_mux_q        <= pc_mux_nxt;
                exc_pc_mux_q    <= exc_pc_mux_nxt;
                trap_addr_mux_q <= trap_addr_mux_nxt;
                irq_id_q        <= irq_id_nxt;
            end
        end
    end

    // A reset in the accept cycle discards the redirect, so no grant escapes.
    assign accept               = (state == ISSUE) && bus.fetch_ready_i && !rst;
    assign bus.pc_set_o         = (state == ISSUE);
    assign bus.pc_mux_o         = pc_mux_q;
    assign bus.exc_pc_mux_o     = exc_pc_mux_q;
    assign bus.trap_addr_mux_o  = trap_addr_mux_q;
    assign bus.irq_id_o         = irq_id_q;
    assign bus.grant_o          = (accept && sel != SEL_BOOT) ? (11'b1 << sel) : 11'b0;
    assign bus.csr_mtvec_init_o = accept && (sel == SEL_BOOT);
    assign bus.busy_o           = (state != RUN);
endmodule

// File: tb/tb_cv32e40p_pc_redirect_ctrl.sv
// Directed bench for the redirect sequencer: boot, priority, stall, fence.i
// preemption, debug-over-exception and reset during a stalled issue.
module tb_cv32e40p_pc_redirect_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cv32e40p_pc_redirect_ctrl_if bus ();

    cv32e40p_pc_redirect_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pc_set"}, 32'(bus.pc_set_o), 0);
        chk({tag, ".grant"}, 32'(bus.grant_o), 0);
        chk({tag, ".mtvec"}, 32'(bus.csr_mtvec_init_o), 0);
        chk({tag, ".irq_id"}, 32'(bus.irq_id_o), 0);
        chk({tag, ".pc_mux"}, 32'(bus.pc_mux_o), 0);
        chk({tag, ".exc_mux"}, 32'(bus.exc_pc_mux_o), 0);
        chk({tag, ".trap"}, 32'(bus.trap_addr_mux_o), 0);
        chk({tag, ".busy"}, 32'(bus.busy_o), 1);
    endtask

    logic [10:0] pri_bit [3];
    logic [3:0]  pri_mux [3];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.fetch_enable_i = 1'b0;
        bus.req_i          = 11'b0;
        bus.irq_id_i       = 5'd0;
        bus.trap_user_i    = 1'b0;
        bus.fence_done_i   = 1'b0;
        bus.fetch_ready_i  = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");

        // Boot redirect
        rst = 1'b0;
        bus.fetch_enable_i = 1'b1;
        bus.fetch_ready_i  = 1'b1;
        tick();
        chk("boot.pc_set", 32'(bus.pc_set_o), 1);
        chk("boot.pc_mux", 32'(bus.pc_mux_o), 32'h0);
        chk("boot.mtvec", 32'(bus.csr_mtvec_init_o), 1);
        chk("boot.grant", 32'(bus.grant_o), 0);
        tick();
        chk("boot.busy", 32'(bus.busy_o), 0);
        chk("boot.pc_set_off", 32'(bus.pc_set_o), 0);
        chk("boot.mtvec_off", 32'(bus.csr_mtvec_init_o), 0);

        // Priority: branch, jump, hwlp served in order, one per 2 cycles
        pri_bit[0] = 11'h008; pri_mux[0] = 4'b0011;
        pri_bit[1] = 11'h002; pri_mux[1] = 4'b0010;
        pri_bit[2] = 11'h001; pri_mux[2] = 4'b1000;
        bus.req_i = 11'h00B;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("pri%0d.pc_set", i), 32'(bus.pc_set_o), 1);
            chk($sformatf("pri%0d.pc_mux", i), 32'(bus.pc_mux_o), 32'(pri_mux[i]));
            chk($sformatf("pri%0d.grant", i), 32'(bus.grant_o), 32'(pri_bit[i]));
            tick();
            bus.req_i = bus.req_i & ~pri_bit[i];
            chk($sformatf("pri%0d.gap", i), 32'(bus.pc_set_o), 0);
        end

        // IRQ to user trap, stalled three cycles
        bus.fetch_ready_i = 1'b0;
        bus.req_i         = 11'h080;
        bus.irq_id_i      = 5'd11;
        bus.trap_user_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("irq%0d.pc_set", i), 32'(bus.pc_set_o), 1);
            chk($sformatf("irq%0d.pc_mux", i), 32'(bus.pc_mux_o), 32'h4);
            chk($sformatf("irq%0d.exc_mux", i), 32'(bus.exc_pc_mux_o), 32'h1);
            chk($sformatf("irq%0d.trap", i), 32'(bus.trap_addr_mux_o), 32'h1);
            chk($sformatf("irq%0d.irq_id", i), 32'(bus.irq_id_o), 32'd11);
            chk($sformatf("irq%0d.grant", i), 32'(bus.grant_o), 0);
        end
        tick();
        bus.fetch_ready_i = 1'b1;
        #1;
        chk("irq.grant", 32'(bus.grant_o), 32'h080);
        chk("irq.pc_mux_hold", 32'(bus.pc_mux_o), 32'h4);
        tick();
        bus.req_i       = 11'h0;
        bus.irq_id_i    = 5'd0;
        bus.trap_user_i = 1'b0;
        chk("irq.done", 32'(bus.pc_set_o), 0);

        // Fence.i preempted by an exception, then completed once drained
        bus.req_i = 11'h004;
        tick();
        chk("fence.wait_pc_set", 32'(bus.pc_set_o), 0);
        chk("fence.wait_busy", 32'(bus.busy_o), 1);
        bus.req_i = 11'h104;
        tick();
        chk("fence.exc_pc_set", 32'(bus.pc_set_o), 1);
        chk("fence.exc_pc_mux", 32'(bus.pc_mux_o), 32'h4);
        chk("fence.exc_mux", 32'(bus.exc_pc_mux_o), 32'h0);
        chk("fence.exc_trap", 32'(bus.trap_addr_mux_o), 32'h0);
        chk("fence.exc_grant", 32'(bus.grant_o), 32'h100);
        tick();
        bus.req_i = 11'h004;
        chk("fence.run", 32'(bus.busy_o), 0);
        tick();
        chk("fence.rewait", 32'(bus.pc_set_o), 0);
        tick();
        chk("fence.still_wait", 32'(bus.pc_set_o), 0);
        chk("fence.no_grant", 32'(bus.grant_o), 0);
        bus.fence_done_i = 1'b1;
        tick();
        chk("fence.pc_set", 32'(bus.pc_set_o), 1);
        chk("fence.pc_mux", 32'(bus.pc_mux_o), 32'h1);
        chk("fence.grant", 32'(bus.grant_o), 32'h004);
        tick();
        bus.req_i        = 11'h0;
        bus.fence_done_i = 1'b0;

        // Debug halt beats exception
        bus.req_i = 11'h500;
        tick();
        chk("dbg.pc_mux", 32'(bus.pc_mux_o), 32'h4);
        chk("dbg.exc_mux", 32'(bus.exc_pc_mux_o), 32'h2);
        chk("dbg.grant", 32'(bus.grant_o), 32'h400);
        tick();
        bus.req_i = 11'h100;
        tick();
        chk("dbg.exc_exc_mux", 32'(bus.exc_pc_mux_o), 32'h0);
        chk("dbg.exc_grant", 32'(bus.grant_o), 32'h100);
        tick();
        bus.req_i = 11'h0;

        // Reset while a dret redirect is stalled
        bus.fetch_ready_i  = 1'b0;
        bus.fetch_enable_i = 1'b0;
        bus.req_i          = 11'h040;
        tick();
        chk("rstmid.pc_set", 32'(bus.pc_set_o), 1);
        chk("rstmid.pc_mux", 32'(bus.pc_mux_o), 32'h7);
        rst = 1'b1;
        #1;
        chk("rstmid.grant", 32'(bus.grant_o), 0);
        tick();
        chk_reset_vals("rstmid");
        rst = 1'b0;
        bus.fetch_ready_i = 1'b1;
        tick();
        chk("rstmid.boot_wait_pc_set", 32'(bus.pc_set_o), 0);
        chk("rstmid.boot_wait_busy", 32'(bus.busy_o), 1);
        chk("rstmid.boot_wait_grant", 32'(bus.grant_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
